// File: rtl/serial_pkg.sv
// Shared definitions for the 8-bit async serial link (sender and receiver).
// Holds the FSM state type, frame constants and the parity helper.
package serial_pkg;

    localparam int DATA_BITS           = 8;
    localparam int DEFAULT_BAUD_CYCLES = 5208;
    localparam int TIMER_WIDTH         = 13;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        BITS  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4,
        ACK   = 3'd5
    } StateType;

    // Odd parity bit: makes the total number of ones (data + parity) odd.
    function automatic logic odd_parity(input logic [DATA_BITS-1:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/baud_timer.sv
// Bit-period timer shared by the serial sender and receiver.
// Counts 0..BAUD_CYCLES-1; timerDone marks the last clock of a bit period
// and the count wraps to 0 on that same edge. clr holds the count at 0.
module baud_timer
    import serial_pkg::*;
#(
    parameter int BAUD_CYCLES = DEFAULT_BAUD_CYCLES
) (
    input  logic clk,
    input  logic clr,
    output logic timerDone
);

    logic [TIMER_WIDTH-1:0] count;

    assign timerDone = (count == TIMER_WIDTH'(BAUD_CYCLES - 1));

    // Free-running bit-period counter, cleared on request or at the end of a period.
    always_ff @(posedge clk) begin
        if (clr || timerDone) begin
            count <= '0;
        end else begin
            count <= count + TIMER_WIDTH'(1);
        end
    end

endmodule

// File: rtl/serial_sender.sv
// Transmitting end of the 8-bit async serial link.
// Frame: start(0), 8 data bits LSB first, [odd parity], stop(1).
// Byte-in uses a four-phase Send/Sent handshake.
// Build option SERIAL_SENDER_PARITY_EN: when defined the parity bit is sent
// (11-level frame); when undefined the frame is 8N1 (10 levels).
module serial_sender
    import serial_pkg::*;
#(
    parameter int BAUD_CYCLES = DEFAULT_BAUD_CYCLES
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 Send,
    input  logic [DATA_BITS-1:0] Din,
    output logic                 Sent,
    output logic                 Sout
);

    StateType               cs, nextState;
    logic [DATA_BITS-1:0]   shift, nextShift;
    logic [2:0]             bitNum, nextBitNum;
    logic                   par, nextPar;
    logic                   nextSout, nextSent;
    logic                   timerClr, timerDone;

    baud_timer #(
        .BAUD_CYCLES(BAUD_CYCLES)
    ) bitTimer (
        .clk       (clk),
        .clr       (timerClr),
        .timerDone (timerDone)
    );

    // Next-state, datapath and line-level decode; outputs are taken from the
    // next state so Sout and Sent change on the same edge as cs.
    always_comb begin
        nextState  = cs;
        nextShift  = shift;
        nextBitNum = bitNum;
        nextPar    = par;
        timerClr   = 1'b0;
        nextSout   = 1'b1;
        nextSent   = 1'b0;

        case (cs)
            IDLE: begin
                timerClr = 1'b1;
                if (Send) begin
                    nextShift = Din;
                    nextPar   = odd_parity(Din);
                    nextState = START;
                end
            end
            START: begin
                if (timerDone) begin
                    nextState  = BITS;
                    nextBitNum = 3'd0;
                end
            end
            BITS: begin
                if (timerDone) begin
                    nextShift  = shift >> 1;
                    nextBitNum = bitNum + 3'd1;
                    if (bitNum == 3'd7) begin
`ifdef SERIAL_SENDER_PARITY_EN
                        nextState = PAR;
`else
                        nextState = STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_SENDER_PARITY_EN
            PAR: begin
                if (timerDone) begin
                    nextState = STOP;
                end
            end
`endif
            STOP: begin
                if (timerDone) begin
                    nextState = ACK;
                end
            end
            ACK: begin
                timerClr = 1'b1;
                if (!Send) begin
                    nextState = IDLE;
                end
            end
            default: begin
                timerClr  = 1'b1;
                nextState = IDLE;
            end
        endcase

        if (Reset) begin
            timerClr = 1'b1;
        end

        case (nextState)
            START:   nextSout = 1'b0;
            BITS:    nextSout = nextShift[0];
            PAR:     nextSout = nextPar;
            default: nextSout = 1'b1;
        endcase
        nextSent = (nextState == ACK);
    end

    // State, shift register, bit counter and registered line outputs.
    always_ff @(posedge clk) begin
        if (Reset) begin
            cs     <= IDLE;
            shift  <= '0;
            bitNum <= 3'd0;
            par    <= 1'b0;
            Sout   <= 1'b1;
            Sent   <= 1'b0;
        end else begin
            cs     <= nextState;
            shift  <= nextShift;
            bitNum <= nextBitNum;
            par    <= nextPar;
            Sout   <= nextSout;
            Sent   <= nextSent;
        end
    end

endmodule

// File: tb/tb_serial_sender.sv
// Self-checking bench for serial_sender with BAUD_CYCLES=16.
// A frame-level reference model predicts every line level from the byte.
module tb_serial_sender;

    localparam int BAUD = 16;
`ifdef SERIAL_SENDER_PARITY_EN
    localparam int NLEVELS = 11;
`else
    localparam int NLEVELS = 10;
`endif

    logic       clk;
    logic       Reset;
    logic       Send;
    logic [7:0] Din;
    logic       Sent;
    logic       Sout;

    int checkCount = 0;
    int errorCount = 0;

    serial_sender #(
        .BAUD_CYCLES(BAUD)
    ) dut (
        .clk   (clk),
        .Reset (Reset),
        .Send  (Send),
        .Din   (Din),
        .Sent  (Sent),
        .Sout  (Sout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed bit against its expected value and log mismatches.
    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s at %0t: got %b expected %b", tag, $time, observed, expected);
        end
    endtask

    // Reference model: line level of frame slot lvl for byte d.
    function automatic logic expLevel(input logic [7:0] d, input int lvl);
        if (lvl == 0) return 1'b0;
        if (lvl <= 8) return d[lvl-1];
`ifdef SERIAL_SENDER_PARITY_EN
        if (lvl == 9) return (($countones(d) % 2) == 0) ? 1'b1 : 1'b0;
`endif
        return 1'b1;
    endfunction

    // Send one byte and check the whole frame and handshake.
    // dropAt: cycle to drop Send mid-frame (-1 none); abortAt: cycle to pulse Reset (-1 none);
    // ackHold: extra cycles Send is held high in ACK.
    task automatic applyStimulus(input logic [7:0] d, input int dropAt, input int abortAt,
                                 input int ackHold);
        int total;
        total = NLEVELS * BAUD;
        @(negedge clk);
        Din  = d;
        Send = 1'b1;
        for (int n = 0; n < total; n++) begin
            @(negedge clk);
            checkOutput("frameSout", Sout, expLevel(d, n / BAUD));
            checkOutput("busySent", Sent, 1'b0);
            Din = 8'($urandom);
            if (n == dropAt) Send = 1'b0;
            if (n == abortAt) begin
                Reset = 1'b1;
                Send  = 1'b0;
                @(negedge clk);
                checkOutput("abortSout", Sout, 1'b1);
                checkOutput("abortSent", Sent, 1'b0);
                Reset = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    checkOutput("postAbortSout", Sout, 1'b1);
                    checkOutput("postAbortSent", Sent, 1'b0);
                end
                return;
            end
        end
        @(negedge clk);
        checkOutput("doneSent", Sent, 1'b1);
        checkOutput("ackSout", Sout, 1'b1);
        if (Send) begin
            for (int i = 0; i < ackHold; i++) begin
                @(negedge clk);
                checkOutput("holdSent", Sent, 1'b1);
                checkOutput("holdSout", Sout, 1'b1);
            end
        end
        Send = 1'b0;
        @(negedge clk);
        checkOutput("clearSent", Sent, 1'b0);
        checkOutput("idleSout", Sout, 1'b1);
    endtask

    initial begin
        Reset = 1'b1;
        Send  = 1'b1;
        Din   = 8'h5A;

        // Reset held 3 cycles with Send high: line stays idle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("resetSout", Sout, 1'b1);
            checkOutput("resetSent", Sent, 1'b0);
        end
        Reset = 1'b0;
        Send  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("idleAfterReset", Sout, 1'b1);
            checkOutput("idleSentAfterReset", Sent, 1'b0);
        end

        $display("[TB] directed frames");
        applyStimulus(8'hA5, -1, -1, 0);
        applyStimulus(8'hFF, -1, -1, 0);
        applyStimulus(8'h01, -1, -1, 0);
        applyStimulus(8'h00, -1, -1, 0);

        // Send held high through ACK, then a back-to-back 3C frame.
        applyStimulus(8'hA5, -1, -1, 6);
        applyStimulus(8'h3C, -1, -1, 0);

        // Reset pulse while sending data bit 4, then a clean frame.
        applyStimulus(8'hC3, -1, 5 * BAUD + 3, 0);
        applyStimulus(8'h96, -1, -1, 0);

        $display("[TB] random frames");
        for (int f = 0; f < 8; f++) begin
            logic [7:0] d;
            int dropAt;
            d      = 8'($urandom);
            dropAt = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NLEVELS * BAUD - 1)) : -1;
            applyStimulus(d, dropAt, -1, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
